// File: rtl/irq_vector_controller.sv
// irq_vector_controller
//   Collects NUM_IRQ asynchronous interrupt sources into a masked, prioritised
//   request for a 65C02-style core. It drives cpu_irqb and substitutes a
//   per-source vector on the core's FFFE/FFFF vector fetch.
//   Optional NMI path is compiled in with the macro IVC_NMI_EN.
// Ports
//   clk, resb             clock, asynchronous active-low reset
//   irq_src[NUM_IRQ]      asynchronous source requests, active high
//   nmi_src               asynchronous NMI request (IVC_NMI_EN only)
//   a, rwb, vpb           snooped CPU address / read-write / vector pull
//   reg_we/addr/wdata     register write port (0 MASK, 1 MODE, 2 PEND, 3 ACTIVE)
//   reg_rdata             combinational register read data
//   cpu_irqb, cpu_nmib    registered active-low interrupt lines to the core
//   vec_sel, vec_data     combinational vector substitution to the data mux
module irq_vector_controller #(
    parameter int unsigned NUM_IRQ     = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [15:0] VEC_BASE    = 16'hFF00
) (
    input  logic               clk,
    input  logic               resb,
    input  logic [NUM_IRQ-1:0] irq_src,
    input  logic               nmi_src,
    input  logic [15:0]        a,
    input  logic               rwb,
    input  logic               vpb,
    input  logic               reg_we,
    input  logic [1:0]         reg_addr,
    input  logic [7:0]         reg_wdata,
    output logic [7:0]         reg_rdata,
    output logic               cpu_irqb,
    output logic               cpu_nmib,
    output logic               vec_sel,
    output logic [7:0]         vec_data
);

    localparam int unsigned ID_W  = 3;
    localparam int unsigned REG_W = 8;

    typedef enum logic [1:0] {ST_IDLE, ST_ASSERT, ST_VLO, ST_VHI} state_e;

    logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_q, sync_d;
    logic [NUM_IRQ-1:0] prev_q, prev_d, synced, rise;
    logic [NUM_IRQ-1:0] mask_q, mask_d, mode_q, mode_d, pend_q, pend_d;
    logic [NUM_IRQ-1:0] req, req_post, svc_clr, w1c, mode_chg;
    state_e             state_q, state_d;
    logic [ID_W-1:0]    id_q, id_d, winner;
    logic               irqb_q, irqb_d;
    logic               fetch_rd, fetch_lo, fetch_hi, found;
    logic               wr_mask, wr_mode, wr_pend;
    logic [15:0]        vec_lo_addr, vec_hi_addr;
    logic               unused_wdata;

    assign fetch_rd = ~vpb & rwb;
    assign fetch_lo = fetch_rd && (a == 16'hFFFE);
    assign fetch_hi = fetch_rd && (a == 16'hFFFF);

    assign wr_mask = reg_we && (reg_addr == 2'd0);
    assign wr_mode = reg_we && (reg_addr == 2'd1);
    assign wr_pend = reg_we && (reg_addr == 2'd2);
    assign unused_wdata = ^reg_wdata;

    // Source synchroniser chain plus edge-detect stage
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], irq_src};
        prev_d = synced;
    end
    assign synced = sync_q[SYNC_STAGES-1];
    assign rise   = synced & ~prev_q;

    // Register file update
    always_comb begin
        mask_d   = wr_mask ? reg_wdata[NUM_IRQ-1:0] : mask_q;
        mode_d   = wr_mode ? reg_wdata[NUM_IRQ-1:0] : mode_q;
        mode_chg = wr_mode ? (mode_q ^ reg_wdata[NUM_IRQ-1:0]) : '0;
        w1c      = wr_pend ? reg_wdata[NUM_IRQ-1:0] : '0;
    end

    // Completion of a vector fetch retires the served edge source
    always_comb begin
        svc_clr = '0;
        if (state_q == ST_VHI) begin
            for (int unsigned k = 0; k < NUM_IRQ; k++) begin
                if (id_q == ID_W'(k)) svc_clr[k] = mode_q[k];
            end
        end
    end

    // Pending bits: level follows the synced input, edge latches (set beats clear)
    always_comb begin
        pend_d = pend_q;
        for (int unsigned k = 0; k < NUM_IRQ; k++) begin
            if (mode_q[k]) pend_d[k] = (pend_q[k] & ~w1c[k] & ~svc_clr[k]) | rise[k];
            else           pend_d[k] = synced[k];
            if (mode_chg[k]) pend_d[k] = 1'b0;
        end
    end

    assign req      = pend_q & mask_q;
    assign req_post = pend_d & mask_q;

    // Fixed priority: lowest index wins
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int unsigned k = 0; k < NUM_IRQ; k++) begin
            if (req[k] && !found) begin
                winner = ID_W'(k);
                found  = 1'b1;
            end
        end
    end

    assign vec_lo_addr = VEC_BASE + 16'({winner, 1'b0});
    assign vec_hi_addr = VEC_BASE + 16'({id_q, 1'b0});

    // Interrupt / vector-fetch FSM next state and outputs
    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        vec_sel  = 1'b0;
        vec_data = 8'h00;
        case (state_q)
            ST_IDLE: begin
                if (req != '0) state_d = ST_ASSERT;
            end
            ST_ASSERT: begin
                if (req == '0) begin
                    state_d = ST_IDLE;
                end else if (fetch_lo) begin
                    id_d     = winner;
                    vec_sel  = 1'b1;
                    vec_data = vec_lo_addr[7:0];
                    state_d  = ST_VLO;
                end
            end
            ST_VLO: begin
                if (fetch_hi) begin
                    vec_sel  = 1'b1;
                    vec_data = vec_hi_addr[15:8];
                    state_d  = ST_VHI;
                end
            end
            ST_VHI: begin
                state_d = (req_post != '0) ? ST_ASSERT : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        irqb_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge resb) begin
        if (!resb) begin
            sync_q  <= '0;
            prev_q  <= '0;
            mask_q  <= '0;
            mode_q  <= '0;
            pend_q  <= '0;
            state_q <= ST_IDLE;
            id_q    <= '0;
            irqb_q  <= 1'b1;
        end else begin
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            mask_q  <= mask_d;
            mode_q  <= mode_d;
            pend_q  <= pend_d;
            state_q <= state_d;
            id_q    <= id_d;
            irqb_q  <= irqb_d;
        end
    end

    assign cpu_irqb = irqb_q;

    // Register read mux
    always_comb begin
        reg_rdata = 8'h00;
        case (reg_addr)
            2'd0: reg_rdata = REG_W'(mask_q);
            2'd1: reg_rdata = REG_W'(mode_q);
            2'd2: reg_rdata = REG_W'(pend_q);
            2'd3: reg_rdata = {(state_q == ST_VLO) || (state_q == ST_VHI), 4'b0000, id_q};
            default: reg_rdata = 8'h00;
        endcase
    end

`ifdef IVC_NMI_EN
    logic [SYNC_STAGES-1:0] nmi_sync_q, nmi_sync_d;
    logic                   nmi_prev_q, nmi_prev_d, nmi_pend_q, nmi_pend_d;

    // NMI: edge-latched, retired by the FFFA vector read
    always_comb begin
        nmi_sync_d = {nmi_sync_q[SYNC_STAGES-2:0], nmi_src};
        nmi_prev_d = nmi_sync_q[SYNC_STAGES-1];
        nmi_pend_d = nmi_pend_q;
        if (fetch_rd && (a == 16'hFFFA)) nmi_pend_d = 1'b0;
        if (nmi_sync_q[SYNC_STAGES-1] && !nmi_prev_q) nmi_pend_d = 1'b1;
    end

    always_ff @(posedge clk or negedge resb) begin
        if (!resb) begin
            nmi_sync_q <= '0;
            nmi_prev_q <= 1'b0;
            nmi_pend_q <= 1'b0;
        end else begin
            nmi_sync_q <= nmi_sync_d;
            nmi_prev_q <= nmi_prev_d;
            nmi_pend_q <= nmi_pend_d;
        end
    end

    assign cpu_nmib = ~nmi_pend_q;
`else
    logic unused_nmi;
    assign unused_nmi = nmi_src;
    assign cpu_nmib   = 1'b1;
`endif

endmodule

// File: tb/tb_irq_vector_controller.sv
module tb_irq_vector_controller;

    localparam int unsigned NUM_IRQ = 8;
    localparam int unsigned SYNC    = 2;
    localparam logic [15:0] VBASE   = 16'hFF00;

    logic        clk = 1'b0;
    logic        resb;
    logic [7:0]  irq_src;
    logic        nmi_src;
    logic [15:0] a;
    logic        rwb, vpb, reg_we;
    logic [1:0]  reg_addr;
    logic [7:0]  reg_wdata, reg_rdata, vec_data;
    logic        cpu_irqb, cpu_nmib, vec_sel;

    int checks = 0;
    int passes = 0;

    irq_vector_controller #(.NUM_IRQ(NUM_IRQ), .SYNC_STAGES(SYNC), .VEC_BASE(VBASE)) dut (
        .clk(clk), .resb(resb), .irq_src(irq_src), .nmi_src(nmi_src),
        .a(a), .rwb(rwb), .vpb(vpb),
        .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
        .cpu_irqb(cpu_irqb), .cpu_nmib(cpu_nmib), .vec_sel(vec_sel), .vec_data(vec_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- reference helpers ----------------
    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [15:0] vec_of(input int src);
        return VBASE + 16'(2 * src);
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] ad, input logic [7:0] d);
        reg_we = 1'b1; reg_addr = ad; reg_wdata = d;
        step();
        reg_we = 1'b0; reg_wdata = 8'h00;
    endtask

    task automatic rd(input logic [1:0] ad, output logic [7:0] d);
        reg_addr = ad;
        #1;
        d = reg_rdata;
    endtask

    task automatic fetch(input logic [15:0] ad, output logic sel, output logic [7:0] d);
        a = ad; vpb = 1'b0; rwb = 1'b1;
        #1;
        sel = vec_sel; d = vec_data;
        step();
        a = 16'h0000; vpb = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic s; logic [7:0] d;
        wr(0, 8'hFF); wr(1, 8'h00);
        irq_src = 8'h02;
        step(SYNC + 3);
        fetch(16'hFFFE, s, d);            // now in VLO
        a = 16'hFFFF; vpb = 1'b0; rwb = 1'b1; reg_addr = 2'd3;
        #1;
        resb = 1'b0;
        #1;
        checks++; if (cpu_irqb !== 1'b1) $display("FAIL rst_irqb got=%b exp=1", cpu_irqb); else passes++;
        checks++; if (vec_sel !== 1'b0) $display("FAIL rst_vec_sel got=%b exp=0", vec_sel); else passes++;
        checks++; if (vec_data !== 8'h00) $display("FAIL rst_vec_data got=%h exp=00", vec_data); else passes++;
        checks++; if (cpu_nmib !== 1'b1) $display("FAIL rst_nmib got=%b exp=1", cpu_nmib); else passes++;
        checks++; if (reg_rdata !== 8'h00) $display("FAIL rst_active got=%h exp=00", reg_rdata); else passes++;
        irq_src = 8'h00; a = 16'h0000; vpb = 1'b1;
        step(2);
        resb = 1'b1;
        step(2);
        for (int r = 0; r < 4; r++) begin
            rd(2'(r), d);
            checks++; if (d !== 8'h00) $display("FAIL rst_reg%0d got=%h exp=00", r, d); else passes++;
        end
        checks++; if (cpu_irqb !== 1'b1) $display("FAIL rst_irqb_after got=%b exp=1", cpu_irqb); else passes++;
    endtask

    task automatic test_priority();
        logic s; logic [7:0] d;
        wr(0, 8'hFF); wr(1, 8'h00);
        irq_src = 8'h24;
        step(SYNC + 1);
        checks++; if (cpu_irqb !== 1'b1) $display("FAIL prio_irqb_early got=%b exp=1", cpu_irqb); else passes++;
        step();
        checks++; if (cpu_irqb !== 1'b0) $display("FAIL prio_irqb got=%b exp=0", cpu_irqb); else passes++;
        fetch(16'hFFFE, s, d);
        checks++; if (s !== 1'b1 || d !== 8'h04) $display("FAIL prio_lo got=%b/%h exp=1/04", s, d); else passes++;
        rd(3, d);
        checks++; if (d !== 8'h82) $display("FAIL prio_active got=%h exp=82", d); else passes++;
        fetch(16'hFFFF, s, d);
        checks++; if (s !== 1'b1 || d !== 8'hFF) $display("FAIL prio_hi got=%b/%h exp=1/FF", s, d); else passes++;
        irq_src = 8'h00;
        step(SYNC + 4);
        checks++; if (cpu_irqb !== 1'b1) $display("FAIL prio_release got=%b exp=1", cpu_irqb); else passes++;
    endtask

    task automatic test_edge_w1c();
        logic [7:0] d;
        wr(0, 8'h00); wr(1, 8'h08);
        irq_src = 8'h08; step(); irq_src = 8'h00;
        step(SYNC + 1);
        rd(2, d);
        checks++; if (d !== 8'h08) $display("FAIL edge_set got=%h exp=08", d); else passes++;
        step(5);
        rd(2, d);
        checks++; if (d !== 8'h08) $display("FAIL edge_hold got=%h exp=08", d); else passes++;
        // new edge reaches PEND in the same cycle as the W1C
        irq_src = 8'h08; step(); irq_src = 8'h00; step();
        wr(2, 8'h08);
        rd(2, d);
        checks++; if (d !== 8'h08) $display("FAIL edge_set_wins got=%h exp=08", d); else passes++;
        step(3);
        wr(2, 8'h08);
        rd(2, d);
        checks++; if (d !== 8'h00) $display("FAIL edge_w1c got=%h exp=00", d); else passes++;
        // W1C on a level channel does nothing
        irq_src = 8'h40; step(SYNC + 2);
        wr(2, 8'h40);
        rd(2, d);
        checks++; if (d !== 8'h40) $display("FAIL level_w1c got=%h exp=40", d); else passes++;
        irq_src = 8'h00; wr(1, 8'h00); step(SYNC + 2);
    endtask

    task automatic test_mask_drop();
        logic s; logic [7:0] d;
        wr(1, 8'h00); wr(0, 8'hFF);
        irq_src = 8'h02;
        step(SYNC + 2);
        checks++; if (cpu_irqb !== 1'b0) $display("FAIL mdrop_irqb_low got=%b exp=0", cpu_irqb); else passes++;
        wr(0, 8'h00);
        step();
        checks++; if (cpu_irqb !== 1'b1) $display("FAIL mdrop_release got=%b exp=1", cpu_irqb); else passes++;
        fetch(16'hFFFE, s, d);
        checks++; if (s !== 1'b0) $display("FAIL mdrop_vec_sel got=%b exp=0", s); else passes++;
        irq_src = 8'h00; step(SYNC + 2);
    endtask

    task automatic test_back_to_back();
        logic s; logic [7:0] d;
        wr(0, 8'hFF); wr(1, 8'hFF);
        irq_src = 8'h81; step(); irq_src = 8'h00;
        step(SYNC + 2);
        fetch(16'hFFFE, s, d);
        checks++; if (s !== 1'b1 || d !== 8'h00) $display("FAIL b2b_lo0 got=%b/%h exp=1/00", s, d); else passes++;
        fetch(16'hFFFF, s, d);
        checks++; if (s !== 1'b1 || d !== 8'hFF) $display("FAIL b2b_hi0 got=%b/%h exp=1/FF", s, d); else passes++;
        step();
        checks++; if (cpu_irqb !== 1'b0) $display("FAIL b2b_irqb_held got=%b exp=0", cpu_irqb); else passes++;
        rd(2, d);
        checks++; if (d !== 8'h80) $display("FAIL b2b_pend got=%h exp=80", d); else passes++;
        fetch(16'hFFFE, s, d);
        checks++; if (s !== 1'b1 || d !== 8'h0E) $display("FAIL b2b_lo7 got=%b/%h exp=1/0E", s, d); else passes++;
        fetch(16'hFFFF, s, d);
        checks++; if (s !== 1'b1 || d !== 8'hFF) $display("FAIL b2b_hi7 got=%b/%h exp=1/FF", s, d); else passes++;
        step();
        rd(2, d);
        checks++; if (d !== 8'h00) $display("FAIL b2b_pend_empty got=%h exp=00", d); else passes++;
        checks++; if (cpu_irqb !== 1'b1) $display("FAIL b2b_release got=%b exp=1", cpu_irqb); else passes++;
        wr(1, 8'h00);
    endtask

    task automatic test_random();
        logic s; logic [7:0] d, m, p, w, pend, req;
        logic [15:0] v;
        int idx;
        for (int it = 0; it < 24; it++) begin
            m = 8'($urandom);
            p = 8'($urandom);
            if (it % 2 == 0) begin
                // level sources
                wr(1, 8'h00); wr(0, m);
                irq_src = p;
                step(SYNC + 3);
                req = p & m;
                rd(2, d);
                checks++; if (d !== p) $display("FAIL rnd_lvl_pend it=%0d got=%h exp=%h", it, d, p); else passes++;
                checks++; if (cpu_irqb !== (req == 8'h00)) $display("FAIL rnd_lvl_irqb it=%0d got=%b exp=%b", it, cpu_irqb, req == 8'h00); else passes++;
                idx = lowest(req);
                fetch(16'hFFFE, s, d);
                if (idx < 0) begin
                    checks++; if (s !== 1'b0) $display("FAIL rnd_lvl_nosel it=%0d got=%b exp=0", it, s); else passes++;
                end else begin
                    v = vec_of(idx);
                    checks++; if (s !== 1'b1 || d !== v[7:0]) $display("FAIL rnd_lvl_lo it=%0d got=%b/%h exp=1/%h", it, s, d, v[7:0]); else passes++;
                    fetch(16'hFFFF, s, d);
                    checks++; if (s !== 1'b1 || d !== v[15:8]) $display("FAIL rnd_lvl_hi it=%0d got=%b/%h exp=1/%h", it, s, d, v[15:8]); else passes++;
                end
                irq_src = 8'h00;
                step(SYNC + 5);
            end else begin
                // edge sources: pulse, random W1C, then drain by priority
                wr(1, 8'hFF); wr(0, m);
                irq_src = p; step(); irq_src = 8'h00;
                step(SYNC + 2);
                pend = p;
                w = 8'($urandom);
                wr(2, w);
                pend = pend & ~w;
                rd(2, d);
                checks++; if (d !== pend) $display("FAIL rnd_edge_pend it=%0d got=%h exp=%h", it, d, pend); else passes++;
                step();
                for (int n = 0; n < 8 && (pend & m) != 8'h00; n++) begin
                    idx = lowest(pend & m);
                    v = vec_of(idx);
                    fetch(16'hFFFE, s, d);
                    checks++; if (s !== 1'b1 || d !== v[7:0]) $display("FAIL rnd_edge_lo it=%0d got=%b/%h exp=1/%h", it, s, d, v[7:0]); else passes++;
                    fetch(16'hFFFF, s, d);
                    checks++; if (s !== 1'b1 || d !== v[15:8]) $display("FAIL rnd_edge_hi it=%0d got=%b/%h exp=1/%h", it, s, d, v[15:8]); else passes++;
                    pend[idx] = 1'b0;
                    step();
                end
                rd(2, d);
                checks++; if (d !== pend) $display("FAIL rnd_edge_left it=%0d got=%h exp=%h", it, d, pend); else passes++;
                checks++; if (cpu_irqb !== 1'b1) $display("FAIL rnd_edge_irqb it=%0d got=%b exp=1", it, cpu_irqb); else passes++;
                wr(2, 8'hFF); wr(1, 8'h00); step(2);
            end
        end
    endtask

    task automatic test_nmi();
        logic s; logic [7:0] d;
`ifdef IVC_NMI_EN
        nmi_src = 1'b1;
        step(SYNC + 2);
        checks++; if (cpu_nmib !== 1'b0) $display("FAIL nmi_assert got=%b exp=0", cpu_nmib); else passes++;
        fetch(16'hFFFA, s, d);
        checks++; if (cpu_nmib !== 1'b1) $display("FAIL nmi_clear got=%b exp=1", cpu_nmib); else passes++;
        checks++; if (s !== 1'b0) $display("FAIL nmi_no_vec got=%b exp=0", s); else passes++;
        nmi_src = 1'b0; step(SYNC + 2);
`else
        for (int i = 0; i < 6; i++) begin
            nmi_src = ~nmi_src;
            step(2);
            checks++; if (cpu_nmib !== 1'b1) $display("FAIL nmi_tied i=%0d got=%b exp=1", i, cpu_nmib); else passes++;
        end
        fetch(16'hFFFA, s, d);
        checks++; if (s !== 1'b0 || cpu_nmib !== 1'b1) $display("FAIL nmi_fffa got=%b/%b exp=0/1", s, cpu_nmib); else passes++;
        nmi_src = 1'b0;
`endif
    endtask

    initial begin
        resb = 1'b0; irq_src = 8'h00; nmi_src = 1'b0;
        a = 16'h0000; rwb = 1'b1; vpb = 1'b1;
        reg_we = 1'b0; reg_addr = 2'd0; reg_wdata = 8'h00;
        step(3);
        resb = 1'b1;
        step(2);
        test_reset();
        test_priority();
        test_edge_w1c();
        test_mask_drop();
        test_back_to_back();
        test_random();
        test_nmi();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
